divisor_bcd_display: RTL

Downstream consumer of the 7-bit divider's result. It captures cociente/residuo on the divider's done pulse, converts both to 3-digit BCD with a sequential double-dabble engine, and holds the BCD results in registers. It also time-multiplexes six active-low seven-segment digits: quotient on digits 5..3, remainder on digits 2..0.

---
 rtl/divisor_bcd_display.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/divisor_bcd_display.sv
// Captures the divider's quotient/remainder, converts each to 3-digit BCD by
// sequential double-dabble, and scans both values onto six seven-segment digits.
//
// state  | meaning
// IDLE   | waiting for done_in; display keeps showing the last result
// SHIFT  | 7 double-dabble iterations, both channels in parallel
// FINISH | publish accumulators to the BCD outputs, pulse bcd_valid
module divisor_bcd_display #(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  cociente,
    input  logic [6:0]  residuo,
    input  logic        done_in,
    output logic [11:0] cociente_bcd,
    output logic [11:0] residuo_bcd,
    output logic        bcd_valid,
    output logic        busy,
    output logic        overrun,
    output logic [5:0]  an,
    output logic [6:0]  seg
);
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_FINISH} state_t;

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(REFRESH_DIV - 1);

    state_t           state_q, state_d;
    logic [6:0]       bin_c_q, bin_c_d, bin_r_q, bin_r_d;
    logic [11:0]      acc_c_q, acc_c_d, acc_r_q, acc_r_d;
    logic [2:0]       iter_q, iter_d;
    logic [11:0]      cociente_bcd_q, cociente_bcd_d, residuo_bcd_q, residuo_bcd_d;
    logic             bcd_valid_q, bcd_valid_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]       digit_idx_q, digit_idx_d;
    logic [5:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic [10:0]      adj_c, adj_r;
    logic [3:0]       disp_nib;
    logic             disp_blank;

    // Hundreds never exceeds 1 for a 7-bit input, so only tens/units need the +3 fix-up.
    function automatic logic [7:0] dd_adjust(input logic [7:0] b);
        logic [7:0] r;
        r[7:4] = (b[7:4] >= 4'd5) ? b[7:4] + 4'd3 : b[7:4];
        r[3:0] = (b[3:0] >= 4'd5) ? b[3:0] + 4'd3 : b[3:0];
        return r;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign adj_c = {acc_c_q[10:8], dd_adjust(acc_c_q[7:0])};
    assign adj_r = {acc_r_q[10:8], dd_adjust(acc_r_q[7:0])};

    always_comb begin
        state_d        = state_q;
        bin_c_d        = bin_c_q;
        bin_r_d        = bin_r_q;
        acc_c_d        = acc_c_q;
        acc_r_d        = acc_r_q;
        iter_d         = iter_q;
        cociente_bcd_d = cociente_bcd_q;
        residuo_bcd_d  = residuo_bcd_q;
        bcd_valid_d    = 1'b0;
        overrun_d      = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (done_in) begin
                    bin_c_d = cociente;
                    bin_r_d = residuo;
                    acc_c_d = '0;
                    acc_r_d = '0;
                    iter_d  = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc_c_d = {adj_c, bin_c_q[6]};
                acc_r_d = {adj_r, bin_r_q[6]};
                bin_c_d = {bin_c_q[5:0], 1'b0};
                bin_r_d = {bin_r_q[5:0], 1'b0};
                if (iter_q == 3'd6) begin
                    state_d = ST_FINISH;
                end else begin
                    iter_d = iter_q + 3'd1;
                end
            end
            ST_FINISH: begin
                cociente_bcd_d = acc_c_q;
                residuo_bcd_d  = acc_r_q;
                bcd_valid_d    = 1'b1;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A strobe arriving in FINISH is dropped too: the FSM is not back in IDLE yet.
        if (done_in && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_comb begin
        scan_cnt_d  = scan_cnt_q + CNT_W'(1);
        digit_idx_d = digit_idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d  = '0;
            digit_idx_d = (digit_idx_q == 3'd5) ? 3'd0 : digit_idx_q + 3'd1;
        end

        disp_nib   = 4'd0;
        disp_blank = 1'b0;
        case (digit_idx_q)
            3'd0: disp_nib = residuo_bcd_q[3:0];
            3'd1: begin
                disp_nib   = residuo_bcd_q[7:4];
                disp_blank = BLANK_LZ && (residuo_bcd_q[11:4] == 8'h00);
            end
            3'd2: begin
                disp_nib   = residuo_bcd_q[11:8];
                disp_blank = BLANK_LZ && (residuo_bcd_q[11:8] == 4'h0);
            end
            3'd3: disp_nib = cociente_bcd_q[3:0];
            3'd4: begin
                disp_nib   = cociente_bcd_q[7:4];
                disp_blank = BLANK_LZ && (cociente_bcd_q[11:4] == 8'h00);
            end
            3'd5: begin
                disp_nib   = cociente_bcd_q[11:8];
                disp_blank = BLANK_LZ && (cociente_bcd_q[11:8] == 4'h0);
            end
            default: disp_blank = 1'b1;
        endcase
        an_d  = ~(6'b000001 << digit_idx_q);
        seg_d = disp_blank ? 7'b1111111 : seg_code(disp_nib);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            bin_c_q        <= '0;
            bin_r_q        <= '0;
            acc_c_q        <= '0;
            acc_r_q        <= '0;
            iter_q         <= '0;
            cociente_bcd_q <= '0;
            residuo_bcd_q  <= '0;
            bcd_valid_q    <= 1'b0;
            overrun_q      <= 1'b0;
            scan_cnt_q     <= '0;
            digit_idx_q    <= '0;
            an_q           <= 6'b111110;
            seg_q          <= 7'b1000000;
        end else begin
            state_q        <= state_d;
            bin_c_q        <= bin_c_d;
            bin_r_q        <= bin_r_d;
            acc_c_q        <= acc_c_d;
            acc_r_q        <= acc_r_d;
            iter_q         <= iter_d;
            cociente_bcd_q <= cociente_bcd_d;
            residuo_bcd_q  <= residuo_bcd_d;
            bcd_valid_q    <= bcd_valid_d;
            overrun_q      <= overrun_d;
            scan_cnt_q     <= scan_cnt_d;
            digit_idx_q    <= digit_idx_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
        end
    end

    assign cociente_bcd = cociente_bcd_q;
    assign residuo_bcd  = residuo_bcd_q;
    assign bcd_valid    = bcd_valid_q;
    assign busy         = (state_q != ST_IDLE);
    assign overrun      = overrun_q;
    assign an           = an_q;
    assign seg          = seg_q;
endmodule
